seg_display_ctrl: RTL and testbench
===================================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, meaning number of multiplexed hex digits (legal 2..16).
REQ-002 SHALL have parameter REFRESH_DIV, default 16384, meaning clk cycles per digit slot (legal >=2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, meaning complete scan frames per blink half-period (legal >=1).
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_valid  input  1  new display data offered.
REQ-007 SHALL have port load_ready  output  1  block can accept new data.
REQ-008 SHALL have port value  input  4*NUM_DIGITS  hex nibbles; nibble k drives digit k; digit 0 = LSB, rightmost.
REQ-009 SHALL have port dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-010 SHALL have port blank_lz  input  1  level; 1 = blank leading zero digits.
REQ-011 SHALL have port blink_en  input  1  level; 1 = blink whole display.
REQ-012 SHALL have port seg  output  7  active-low segments; seg[6]=a ... seg[0]=g.
REQ-013 SHALL have port dp  output  1  active-low decimal point.
REQ-014 SHALL have port an  output  NUM_DIGITS  active-low anodes; an[k] selects digit k.

Function
REQ-015 Transfer: load accepted on a clk edge where load_valid=1 and load_ready=1; value and dp_in captured into the pending register; pending_valid set.
REQ-016 load_ready SHALL equal NOT pending_valid; while pending_valid=1, load_valid SHALL be ignored and source data not sampled.
REQ-017 Prescaler counts 0..REFRESH_DIV-1, wraps to 0; tick = cycle at terminal count.
REQ-018 On tick, digit index idx SHALL increment; NUM_DIGITS-1 wraps to 0 (frame boundary).
REQ-019 At frame boundary with pending_valid=1, pending SHALL be copied to the display register and pending_valid cleared in the same edge; display register otherwise unchanged (no mid-frame tearing).
REQ-020 Load accepted on the same edge as a frame boundary SHALL NOT be displayed until the following frame boundary.
REQ-021 Blink counter counts frame boundaries 0..BLINK_FRAMES-1; blink_phase toggles on its wrap; counter runs regardless of blink_en.
REQ-022 Leading-zero blank: with blank_lz=1, digit k (k>=1) blanked if display nibbles k..NUM_DIGITS-1 are all zero; digit 0 never blanked.
REQ-023 Slot is dark (an all 1s, seg=7'h7F, dp=1) when current digit blanked, or blink_en=1 and blink_phase=1.
REQ-024 Otherwise an SHALL have only bit idx low; seg = hex glyph of nibble idx; dp = NOT dp bit idx.
REQ-025 Glyphs (seg, a..g, active-low): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0000010 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-026 seg, dp, an SHALL be registered; they reflect idx/display state exactly 1 clk after idx changes; never two anodes low in any cycle.
REQ-027 blank_lz and blink_en SHALL take effect at next output register update (1 clk latency).

Reset
REQ-028 While rst=1: prescaler=0, idx=0, blink counter=0, blink_phase=0, display register=0, pending_valid=0, load_ready=0, an all 1s, seg=7'h7F, dp=1.
REQ-029 Reset asserted mid-frame or with pending data SHALL discard pending data; load_ready=1 from first clk edge after rst deasserts.
REQ-030 First digit slot after reset SHALL show digit 0 of value 0 (an=...1110, seg=0000001) starting 1 clk after rst release.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-031 Load 16'h12AF at reset release -> an cycles 1110,1101,1011,0111 every 4 clks; first frame shows 0000; next frame seg F,A,2,1.
REQ-032 Load 16'h0005, blank_lz=1 -> only an=1110 ever low, seg=0100100; other slots dark; blank_lz=0 -> 0,0,0 shown.
REQ-033 Load accepted, second load_valid held -> load_ready=0 until frame boundary, then 1; second value shown one frame later.
REQ-034 blink_en=1 -> display lit 2 frames, dark 2 frames, repeating; blink_en=0 -> steady.
REQ-035 Assert rst mid-frame with pending data -> outputs dark within same cycle (asynchronous); after release display 0000, pending lost.
REQ-036 dp_in=4'b0100 -> dp=0 only during an=1011 slot; never two anodes low across random load/blink stress.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// Multiplexed 7-segment hex display controller with double-buffered load,
// leading-zero blanking and whole-display blink.
module seg_display_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 16384,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  // Active-low a..g glyph for one hex nibble.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0000010;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      4'hF:    g = 7'b0111000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
  logic                    blk_phase_q, blk_phase_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                    pvalid_q, pvalid_d;
  logic                    ready_q, ready_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick_s, frame_end_s, accept_s;
  logic [3:0]              nib_s [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_mask_s;
  logic                    nz_above_s, dark_s;

  assign load_ready = ready_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;

  // Scan timing, blink timing and the pending/display double buffer.
  always_comb begin
    tick_s      = (pre_q == PRE_LAST);
    frame_end_s = tick_s && (idx_q == IDX_LAST);
    accept_s    = load_valid && ready_q;

    pre_d       = tick_s ? '0 : pre_q + PRE_W'(1);
    idx_d       = idx_q;
    blk_cnt_d   = blk_cnt_q;
    blk_phase_d = blk_phase_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pvalid_d    = pvalid_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;

    if (tick_s) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end

    if (frame_end_s) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d   = '0;
        blk_phase_d = ~blk_phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end else begin
      blk_cnt_d = blk_cnt_q;
    end

    // ready_q mirrors !pvalid_q, so accept and swap are mutually exclusive;
    // a load landing on a frame edge therefore waits a full frame.
    if (accept_s) begin
      pend_d    = value;
      pend_dp_d = dp_in;
      pvalid_d  = 1'b1;
    end else if (frame_end_s && pvalid_q) begin
      disp_d    = pend_q;
      disp_dp_d = pend_dp_q;
      pvalid_d  = 1'b0;
    end else begin
      pvalid_d = pvalid_q;
    end

    ready_d = ~pvalid_d;
  end

  // Output decode for the current slot, including blanking and blink.
  always_comb begin
    nz_above_s = 1'b0;
    lz_mask_s  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib_s[k]     = disp_q[4*k +: 4];
      nz_above_s   = nz_above_s | (disp_q[4*k +: 4] != 4'h0);
      lz_mask_s[k] = ~nz_above_s;
    end
    lz_mask_s[0] = 1'b0;

    dark_s = (blank_lz && lz_mask_s[idx_q]) || (blink_en && blk_phase_q);

    if (dark_s) begin
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = (idx_q != IDX_W'(k));
      end
      seg_d = hex_glyph(nib_s[idx_q]);
      dp_d  = ~disp_dp_q[idx_q];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q       <= '0;
      idx_q       <= '0;
      blk_cnt_q   <= '0;
      blk_phase_q <= 1'b0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pvalid_q    <= 1'b0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      ready_q     <= 1'b0;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      an_q        <= '1;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      blk_cnt_q   <= blk_cnt_d;
      blk_phase_q <= blk_phase_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
      pvalid_q    <= pvalid_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      ready_q     <= ready_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with a 4-digit, 4-clock-slot, 2-frame-blink build.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_checks = 0;
  int n_fails  = 0;
  bit mon_en   = 1'b0;

  seg_display_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .value     (value),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .blink_en  (blink_en),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp_v);
    end
  endtask

  // Advance n rising edges, then park on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_slot(input string tag, input logic [3:0] an_e,
                            input logic [6:0] seg_e, input logic dp_e);
    check_eq({tag, "_an"},  32'(an),  32'(an_e));
    check_eq({tag, "_seg"}, 32'(seg), 32'(seg_e));
    check_eq({tag, "_dp"},  32'(dp),  32'(dp_e));
  endtask

  // Called on the first cycle of slot 0; ends on the first cycle of slot 3.
  task automatic check_frame(input string tag, input logic [15:0] an_e,
                             input logic [27:0] seg_e, input logic [3:0] dp_e);
    for (int i = 0; i < 4; i++) begin
      check_slot(tag, an_e[i*4 +: 4], seg_e[i*7 +: 7], dp_e[i]);
      if (i < 3) step(4);
    end
  endtask

  // Assert reset (checked asynchronously) and hold it; caller releases.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_slot({tag, "_rst_async"}, 4'hF, 7'h7F, 1'b1);
    check_eq({tag, "_rst_ready"}, 32'(load_ready), 32'd0);
    step(2);
    check_slot({tag, "_rst_hold"}, 4'hF, 7'h7F, 1'b1);
    load_valid = 1'b0;
    blank_lz   = 1'b0;
    blink_en   = 1'b0;
    dp_in      = 4'h0;
    value      = 16'h0000;
  endtask

  always @(negedge clk) begin
    if (mon_en) check_eq("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  end

  initial begin
    step(1);
    do_reset("t1");
    mon_en = 1'b1;

    // Load at reset release; first frame shows zeros, second shows the value.
    value = 16'h12AF; load_valid = 1'b1; rst = 1'b0;
    step(1);
    check_slot("t1_e1", 4'hE, 7'h01, 1'b1);
    check_eq("t1_ready_e1", 32'(load_ready), 32'd1);
    step(1);
    check_eq("t1_ready_e2", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    step(3);
    check_slot("t1_e5", 4'hD, 7'h01, 1'b1);
    step(8);
    check_slot("t1_e13", 4'h7, 7'h01, 1'b1);
    check_eq("t1_ready_e13", 32'(load_ready), 32'd0);
    step(3);
    check_eq("t1_ready_e16", 32'(load_ready), 32'd1);
    step(1);
    check_frame("t1_f2", 16'h7BDE, {7'h4F, 7'h12, 7'h02, 7'h38}, 4'hF);

    // Leading-zero blanking on and then off.
    do_reset("t2");
    value = 16'h0005; blank_lz = 1'b1; load_valid = 1'b1; rst = 1'b0;
    step(1);
    check_slot("t2_e1", 4'hE, 7'h01, 1'b1);
    step(1);
    load_valid = 1'b0;
    step(3);
    check_slot("t2_e5", 4'hF, 7'h7F, 1'b1);
    step(12);
    check_frame("t2_f2", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h24}, 4'hF);
    blank_lz = 1'b0;
    step(4);
    check_frame("t2_f3", 16'h7BDE, {7'h01, 7'h01, 7'h01, 7'h24}, 4'hF);

    // Back-to-back loads: second held off until the frame swap.
    do_reset("t3");
    value = 16'h89BC; load_valid = 1'b1; rst = 1'b0;
    step(2);
    check_eq("t3_ready_e2", 32'(load_ready), 32'd0);
    value = 16'hDE76;
    step(13);
    check_eq("t3_ready_e15", 32'(load_ready), 32'd0);
    step(1);
    check_eq("t3_ready_e16", 32'(load_ready), 32'd1);
    step(1);
    check_eq("t3_ready_e17", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    check_frame("t3_f2", 16'h7BDE, {7'h00, 7'h04, 7'h60, 7'h31}, 4'hF);
    step(4);
    check_frame("t3_f3", 16'h7BDE, {7'h42, 7'h30, 7'h0F, 7'h20}, 4'hF);
    check_eq("t3_ready_end", 32'(load_ready), 32'd1);

    // Blink: two frames lit, two dark; disabling takes effect next clock.
    do_reset("t4");
    blink_en = 1'b1; rst = 1'b0;
    step(1);
    for (int f = 0; f < 7; f++) begin
      if ((f % 4) >= 2) check_slot($sformatf("t4_f%0d", f), 4'hF, 7'h7F, 1'b1);
      else              check_slot($sformatf("t4_f%0d", f), 4'hE, 7'h01, 1'b1);
      if (f < 6) step(16);
    end
    blink_en = 1'b0;
    step(1);
    check_slot("t4_off", 4'hE, 7'h01, 1'b1);
    step(4);
    check_slot("t4_steady", 4'hD, 7'h01, 1'b1);

    // Reset mid-frame with pending data discards it.
    do_reset("t5");
    value = 16'h8888; load_valid = 1'b1; rst = 1'b0;
    step(2);
    load_valid = 1'b0;
    step(8);
    do_reset("t5_mid");
    rst = 1'b0;
    step(1);
    check_slot("t5_e1", 4'hE, 7'h01, 1'b1);
    check_eq("t5_ready_e1", 32'(load_ready), 32'd1);
    step(16);
    check_slot("t5_e17", 4'hE, 7'h01, 1'b1);
    step(4);
    check_slot("t5_e21", 4'hD, 7'h01, 1'b1);

    // Decimal point on digit 2, then random stress under the anode monitor.
    do_reset("t6");
    value = 16'h1234; dp_in = 4'b0100; load_valid = 1'b1; rst = 1'b0;
    step(2);
    load_valid = 1'b0;
    step(15);
    check_frame("t6_f2", 16'h7BDE, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1011);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      load_valid = 1'($urandom_range(0, 1));
      value      = 16'($urandom);
      dp_in      = 4'($urandom);
      blank_lz   = 1'($urandom_range(0, 1));
      blink_en   = 1'($urandom_range(0, 1));
    end
    step(1);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
